timer_dev: RTL and testbench
============================

# timer_dev

Memory-mapped countdown timer that acts as a responder on the CPU data-side bus. The pipeline's MEM stage (through the address bridge) is the initiator: it issues register loads and stores to the timer. The timer answers with combinational read data and an interrupt request line. It holds three word registers (CTRL, PRESET, COUNT) and runs a four-state counting FSM, giving the pipelined MIPS core its first interrupt source.

## Interface
Parameters:
- None.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  reset, asynchronous and active-low; clears every register and the FSM
- sel  input  1  device select from the bus bridge; qualifies we and rdata
- addr  input  2  word address within the device (CPU address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- we  input  1  write strobe; effective only when sel=1
- be  input  4  byte enables for a write; be[i] covers wdata[8i+7:8i]
- wdata  input  32  store data from the CPU
- rdata  output  32  load data to the CPU, combinational
- irq  output  1  interrupt request, level, equals irq_flag AND CTRL[3]

## Operation
CTRL register, 4 bits, read zero-extended:
- [0] EN: enable
- [2:1] MODE: 00 = one-shot, 01 = auto-reload, 1x = treated as 00
- [3] IM: interrupt mask, 1 = irq allowed

Other registers:
- PRESET: 32-bit reload value, read/write.
- COUNT: 32-bit, read-only. Writes to it are ignored.

Writes:
- A write takes effect on the clock edge where sel=1 and we=1.
- Each byte lane updates only if its be bit is 1. For CTRL, only bits [3:0] of lane 0 are stored.
- Any write to CTRL clears irq_flag.

Reads:
- When sel=1, rdata = the addressed register. Address 3 reads 0.
- When sel=0, rdata = 0.

FSM states: IDLE, LOAD, CNT, INT.
- IDLE: if EN=1, go to LOAD.
- LOAD: COUNT <= PRESET, go to CNT.
- CNT:
  - If EN=0, go to IDLE and hold COUNT.
  - Else if COUNT==0, go to INT and set irq_flag.
  - Else COUNT <= COUNT-1.
- INT:
  - MODE 00: clear EN, go to IDLE. irq_flag stays set until the next CTRL write.
  - MODE 01: go to LOAD and clear irq_flag, which makes a one-cycle pulse.

Boundary rules:
- PRESET=0: CNT sees 0 on its first cycle and goes to INT.
- COUNT never wraps below 0.
- A CPU write to CTRL in the same edge as INT's EN clear: the CPU value wins.
- Writing CTRL with EN=0 in any state: the FSM goes to IDLE on the next edge. COUNT is held and irq_flag is cleared.
- A PRESET write during CNT does not affect COUNT until the next LOAD.
- A CTRL write in the same edge that sets irq_flag (CNT to INT): the flag set wins.
- IM=0 masks irq only. irq_flag still sets and clears normally.
- Reset asserted mid-count: every register clears immediately. No interrupt is produced afterward.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, irq=0. With sel=0, rdata=0.
- Read latency: 0 cycles. rdata settles in the same cycle as sel/addr, matching the MEM-stage combinational load path.
- Write latency: the register holds the new value after the write edge. A read in the following cycle returns it.
- Edge sequence after a CTRL write that sets EN at edge e:
  - e+1: LOAD.
  - e+2: COUNT=PRESET, CNT.
  - e+2+PRESET: COUNT=0.
  - e+3+PRESET: INT, irq_flag=1.
- irq rises PRESET+3 cycles after the enabling write.
- One-shot: EN reads 0 from edge e+4+PRESET.
- Auto-reload: irq pulses high for exactly 1 cycle every PRESET+3 cycles.
- No stall or wait signalling: every access completes in one cycle.

## Test plan
- Reset and readback: hold reset low mid-operation, then release. Expect every register to read 0 and irq=0. Write PRESET=0x12345678 with be=0xF and read it back as 0x12345678. Write be=0x2 with wdata=0xFFFFFFFF and expect PRESET=0x1234FF78.
- One-shot: PRESET=3, then CTRL=0x9. Expect irq=1 from the 6th edge after the CTRL write. Expect COUNT to read 3,2,1,0. Expect CTRL to read 0x8 afterward. Expect irq to stay 1 until CTRL=0x0 is written, then drop to 0.
- Auto-reload: PRESET=2, CTRL=0xB. Expect one-cycle irq pulses every 5 cycles for at least 4 periods.
- Masking: PRESET=1, CTRL=0x1. Expect irq=0 throughout and the FSM back in IDLE. Then write CTRL=0x8; irq stays 0 because the write cleared irq_flag.
- Disable mid-count: PRESET=100, CTRL=0x1. Write CTRL=0x0 when COUNT=50. Expect COUNT frozen at 50, no irq, and the state returned to IDLE. Re-enabling reloads COUNT to 100.
- Access rules: a write to COUNT leaves it unchanged. Address 3 reads 0. With sel=0, rdata=0 and we has no effect.

Source files
------------

// File: rtl/timer_dev.sv
`default_nettype none
// ============================================================================
// Module      : timer_dev
// Description : Memory-mapped countdown timer that responds on the CPU
//               data-side bus. It holds three word registers and one
//               interrupt request line.
//                 addr 0 : CTRL   [0] EN, [2:1] MODE, [3] IM (others read 0)
//                 addr 1 : PRESET 32-bit reload value, read/write
//                 addr 2 : COUNT  32-bit down-counter, read-only
//                 addr 3 : reserved, reads 0
//               A four-state FSM (IDLE -> LOAD -> CNT -> INT) loads COUNT
//               from PRESET, counts it down to zero and raises irq_flag.
//               MODE 01 reloads automatically. Any other MODE is one-shot.
// Ports       : clk    - system clock, rising-edge active
//               reset  - asynchronous active-low reset
//               sel    - device select, qualifies we and rdata
//               addr   - word address within the device
//               we     - write strobe (only when sel=1)
//               be     - byte enables for writes
//               wdata  - store data
//               rdata  - combinational load data (0 when sel=0)
//               irq    - level interrupt request = irq_flag & CTRL.IM
// Revision    : 1.0 - initial release
// ============================================================================
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_PRESET = 2'd1;
    localparam logic [1:0] c_ADDR_COUNT  = 2'd2;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_CNT  = 2'd2;
    localparam logic [1:0] c_ST_INT  = 2'd3;

    localparam logic [1:0] c_MODE_RELOAD = 2'b01;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_en_after_wr;
    logic        w_disable_wr;
    logic        w_load;
    logic        w_dec;
    logic        w_set_flag;
    logic        w_clr_flag_fsm;
    logic        w_clr_en;

    // ------------------------------------------------------------------------
    // Bus write decode
    // ------------------------------------------------------------------------
    assign w_wr        = sel & we;
    assign w_wr_ctrl   = w_wr & (addr == c_ADDR_CTRL);
    assign w_wr_preset = w_wr & (addr == c_ADDR_PRESET);

    // EN value after a CTRL write; lane 0 must be enabled for EN to change.
    assign w_en_after_wr = be[0] ? wdata[0] : r_ctrl[0];
    // A CTRL write that leaves EN=0 stops the timer on this very edge,
    // so COUNT is frozen at the value the CPU last saw.
    assign w_disable_wr  = w_wr_ctrl & ~w_en_after_wr;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and datapath controls
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_dec          = 1'b0;
        w_set_flag     = 1'b0;
        w_clr_flag_fsm = 1'b0;
        w_clr_en       = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (r_ctrl[0]) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = c_ST_CNT;
            end
            c_ST_CNT: begin
                if (!r_ctrl[0]) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_count == 32'd0) begin
                    w_state_nxt = c_ST_INT;
                    w_set_flag  = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            c_ST_INT: begin
                if (r_ctrl[2:1] == c_MODE_RELOAD) begin
                    // Clearing here turns the flag into a one-cycle pulse.
                    w_state_nxt    = c_ST_LOAD;
                    w_clr_flag_fsm = 1'b1;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                    w_clr_en    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // CPU disable overrides the FSM: return to IDLE, COUNT untouched.
        // The flag set above is deliberately kept (set beats clear).
        if (w_disable_wr) begin
            w_state_nxt = c_ST_IDLE;
            w_load      = 1'b0;
            w_dec       = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // CTRL register. The FSM's EN clear is applied first so that a CPU
    // write to lane 0 on the same edge takes precedence.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl <= 4'd0;
        end else begin
            if (w_clr_en) begin
                r_ctrl[0] <= 1'b0;
            end
            if (w_wr_ctrl && be[0]) begin
                r_ctrl <= wdata[3:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // PRESET register with per-byte enables
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_preset <= 32'd0;
        end else if (w_wr_preset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    r_preset[8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // COUNT register. It is only ever decremented from a nonzero value,
    // so it cannot wrap. Bus writes to it are ignored.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 32'd0;
        end else if (w_load) begin
            r_count <= r_preset;
        end else if (w_dec) begin
            r_count <= r_count - 32'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Interrupt flag. Setting has priority over every clear source.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_flag <= 1'b0;
        end else if (w_set_flag) begin
            r_irq_flag <= 1'b1;
        end else if (w_wr_ctrl || w_clr_flag_fsm) begin
            r_irq_flag <= 1'b0;
        end
    end

    assign irq = r_irq_flag & r_ctrl[3];

    // ------------------------------------------------------------------------
    // Combinational read mux
    // ------------------------------------------------------------------------
    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (addr)
                c_ADDR_CTRL:   rdata = {28'd0, r_ctrl};
                c_ADDR_PRESET: rdata = r_preset;
                c_ADDR_COUNT:  rdata = r_count;
                default:       rdata = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_dev.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_dev
// Description : Self-checking bench for timer_dev. A table of single-cycle
//               bus accesses with expected read data covers register access
//               rules. Hand-written sequences cover the multi-cycle timer
//               behaviour: one-shot, auto-reload, masking, disable, and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    timer_dev u_dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .we    (we),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [1:0]  addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    localparam int c_NVEC = 21;
    vec_t tbl [c_NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Write one register; returns 1 ns after the edge that performs the write.
    task automatic wr(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
        @(negedge clk);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        be    = b;
        wdata = d;
        @(posedge clk);
        #1;
        sel = 1'b0;
        we  = 1'b0;
    endtask

    // Combinational read; takes 1 ns and does not cross a clock edge
    // when issued shortly after a rising edge.
    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        d   = rdata;
        sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int          irq_seen;
        string       nm;

        // Access-rule vectors, all applied from the reset state.
        tbl[0]  = '{1'b1, 2'd0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0};
        tbl[1]  = '{1'b1, 2'd1, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0};
        tbl[3]  = '{1'b1, 2'd3, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0};
        tbl[4]  = '{1'b0, 2'd1, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0};
        tbl[5]  = '{1'b1, 2'd1, 1'b1, 4'hF, 32'h12345678, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 2'd1, 1'b0, 4'h0, 32'h0,        32'h12345678, 1'b0};
        tbl[7]  = '{1'b1, 2'd1, 1'b1, 4'h2, 32'hFFFFFFFF, 32'h12345678, 1'b0};
        tbl[8]  = '{1'b1, 2'd1, 1'b0, 4'h0, 32'h0,        32'h1234FF78, 1'b0};
        tbl[9]  = '{1'b1, 2'd2, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 2'd2, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0};
        tbl[11] = '{1'b0, 2'd1, 1'b1, 4'hF, 32'h0,        32'h0,        1'b0};
        tbl[12] = '{1'b1, 2'd1, 1'b0, 4'h0, 32'h0,        32'h1234FF78, 1'b0};
        tbl[13] = '{1'b1, 2'd3, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b0};
        tbl[14] = '{1'b1, 2'd3, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0};
        tbl[15] = '{1'b1, 2'd0, 1'b1, 4'h1, 32'hFFFFFFF6, 32'h0,        1'b0};
        tbl[16] = '{1'b1, 2'd0, 1'b0, 4'h0, 32'h0,        32'h6,        1'b0};
        tbl[17] = '{1'b1, 2'd0, 1'b1, 4'hE, 32'hFFFFFFFF, 32'h6,        1'b0};
        tbl[18] = '{1'b1, 2'd0, 1'b0, 4'h0, 32'h0,        32'h6,        1'b0};
        tbl[19] = '{1'b1, 2'd0, 1'b1, 4'hF, 32'h0,        32'h6,        1'b0};
        tbl[20] = '{1'b1, 2'd0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0};

        reset = 1'b0;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        be    = 4'h0;
        wdata = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // ---------------- Reset asserted mid-count ----------------
        wr(2'd1, 4'hF, 32'd100);
        wr(2'd0, 4'hF, 32'h9);
        repeat (10) @(posedge clk);
        #1;
        rd(2'd2, d);
        chk("count_before_reset", d, 32'd92);
        #3;
        reset = 1'b0;
        #1;
        rd(2'd2, d); chk("count_in_reset", d, 32'd0);
        rd(2'd0, d); chk("ctrl_in_reset", d, 32'd0);
        rd(2'd1, d); chk("preset_in_reset", d, 32'd0);
        chk("irq_in_reset", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        irq_seen = 0;
        repeat (110) begin
            @(posedge clk);
            #1;
            if (irq) irq_seen++;
        end
        chk("no_irq_after_reset", irq_seen, 0);

        // ---------------- Table-driven access rules ----------------
        for (int i = 0; i < c_NVEC; i++) begin
            @(negedge clk);
            sel   = tbl[i].sel;
            addr  = tbl[i].addr;
            we    = tbl[i].we;
            be    = tbl[i].be;
            wdata = tbl[i].wdata;
            #1;
            nm = $sformatf("vec%0d_rdata", i);
            chk(nm, rdata, tbl[i].exp_rdata);
            nm = $sformatf("vec%0d_irq", i);
            chk(nm, {31'd0, irq}, {31'd0, tbl[i].exp_irq});
        end
        @(negedge clk);
        sel = 1'b0;
        we  = 1'b0;

        // ---------------- One-shot, PRESET=3 ----------------
        wr(2'd1, 4'hF, 32'd3);
        wr(2'd0, 4'hF, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            rd(2'd2, d);
            nm = $sformatf("oneshot_count_e%0d", k);
            chk(nm, d, (k >= 2 && k <= 5) ? 32'(5 - k) : 32'd0);
            rd(2'd0, d);
            nm = $sformatf("oneshot_ctrl_e%0d", k);
            chk(nm, d, (k >= 7) ? 32'h8 : 32'h9);
            nm = $sformatf("oneshot_irq_e%0d", k);
            chk(nm, {31'd0, irq}, (k >= 6) ? 32'd1 : 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("oneshot_irq_held", {31'd0, irq}, 32'd1);
        wr(2'd0, 4'hF, 32'h0);
        chk("oneshot_irq_cleared", {31'd0, irq}, 32'd0);

        // ---------------- Auto-reload, PRESET=2 ----------------
        wr(2'd1, 4'hF, 32'd2);
        wr(2'd0, 4'hF, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk);
            #1;
            nm = $sformatf("reload_irq_e%0d", k);
            chk(nm, {31'd0, irq}, (k >= 5 && (k % 5) == 0) ? 32'd1 : 32'd0);
        end
        wr(2'd0, 4'hF, 32'h0);

        // ---------------- Masking, PRESET=1 ----------------
        wr(2'd1, 4'hF, 32'd1);
        wr(2'd0, 4'hF, 32'h1);
        irq_seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (irq) irq_seen++;
        end
        chk("mask_no_irq", irq_seen, 0);
        rd(2'd0, d); chk("mask_ctrl_en_cleared", d, 32'h0);
        rd(2'd2, d); chk("mask_count_zero", d, 32'd0);
        wr(2'd0, 4'hF, 32'h8);
        chk("mask_unmask_irq0", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        chk("mask_unmask_irq1", {31'd0, irq}, 32'd0);
        wr(2'd0, 4'hF, 32'h0);

        // ---------------- Disable mid-count, PRESET=100 ----------------
        wr(2'd1, 4'hF, 32'd100);
        wr(2'd0, 4'hF, 32'h1);
        repeat (52) @(posedge clk);
        #1;
        rd(2'd2, d);
        chk("disable_count_at_50", d, 32'd50);
        wr(2'd0, 4'hF, 32'h0);
        irq_seen = 0;
        for (int k = 0; k < 5; k++) begin
            rd(2'd2, d);
            nm = $sformatf("disable_count_frozen%0d", k);
            chk(nm, d, 32'd50);
            if (irq) irq_seen++;
            @(posedge clk);
            #1;
        end
        chk("disable_no_irq", irq_seen, 0);
        rd(2'd0, d); chk("disable_ctrl", d, 32'h0);
        wr(2'd0, 4'hF, 32'h1);
        @(posedge clk);
        #1;
        rd(2'd2, d); chk("reenable_count_e1", d, 32'd50);
        @(posedge clk);
        #1;
        rd(2'd2, d); chk("reenable_count_e2", d, 32'd100);
        @(posedge clk);
        #1;
        rd(2'd2, d); chk("reenable_count_e3", d, 32'd99);
        wr(2'd0, 4'hF, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
